// File: rtl/morty_ifetch_port_if.sv
// Fetch-port signal bundle: IF-stage request/response plus the Wishbone
// classic read channel toward instruction memory. The port itself uses the
// slave view (it answers the IF stage); the IF stage/bus model uses master.
interface morty_ifetch_port_if;
  // IF stage side
  logic [31:0] if_pc_i;
  logic        if_req_i;
  logic        if_kill_i;
  logic [31:0] if_instruction_o;
  logic        if_inst_access_fault_o;
  logic        if_ready_o;
  logic        if_stall_o;

  // Wishbone classic instruction bus side
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport slave (
    input  if_pc_i,
    input  if_req_i,
    input  if_kill_i,
    output if_instruction_o,
    output if_inst_access_fault_o,
    output if_ready_o,
    output if_stall_o,
    output wb_adr_o,
    output wb_cyc_o,
    output wb_stb_o,
    output wb_sel_o,
    output wb_we_o,
    input  wb_dat_i,
    input  wb_ack_i,
    input  wb_err_i
  );

  modport master (
    output if_pc_i,
    output if_req_i,
    output if_kill_i,
    input  if_instruction_o,
    input  if_inst_access_fault_o,
    input  if_ready_o,
    input  if_stall_o,
    input  wb_adr_o,
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_sel_o,
    input  wb_we_o,
    output wb_dat_i,
    output wb_ack_i,
    output wb_err_i
  );
endinterface

// File: rtl/morty_ifetch_port.sv
// Instruction-fetch bus port. Turns an IF-stage fetch request into a single
// Wishbone classic read, returns the word (or a NOP plus access fault) as a
// one-cycle ready pulse, and stalls the IF stage while the fetch is pending.
// A kill while the bus cycle is open cannot abort the slave, so the cycle is
// finished silently in KILLED and its result thrown away.
module morty_ifetch_port #(
  parameter logic [7:0] TIMEOUT = 8'd255  // legal range 1..255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  morty_ifetch_port_if.slave   bus
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    KILLED
  } state_e;

  state_e      state_q;
  logic        cyc_q;
  logic [31:0] adr_q;
  logic [31:0] instr_q;
  logic        fault_q;
  logic        ready_q;
  logic [7:0]  cnt_q;

  logic        ready;
  logic        start;
  logic        aligned;
  logic        timeout_hit;
  logic        bus_resp;
  logic [7:0]  cnt_inc;

  // A kill in the response cycle swallows the response.
  assign ready       = ready_q & ~bus.if_kill_i;
  // No new fetch during the response cycle: the PC has not advanced yet.
  assign start       = bus.if_req_i & ~ready & ~bus.if_kill_i;
  assign aligned     = (bus.if_pc_i[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == (TIMEOUT - 8'd1));
  assign bus_resp    = bus.wb_ack_i | bus.wb_err_i;
  // Saturating increment so a long wait can never wrap back into range.
  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Fetch FSM; all bus and response outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= 32'h0;
      instr_q <= NOP_INSN;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      // NOTE: non-blocking assignments only in clocked blocks, so every
      // branch below sees the pre-edge register values regardless of order.
      ready_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (aligned) begin
              adr_q   <= {bus.if_pc_i[31:2], 2'b00};
              cyc_q   <= 1'b1;
              cnt_q   <= 8'h0;
              state_q <= BUS;
            end else begin
              // Misaligned PC: answer with a harmless NOP, no bus access;
              // the IF stage raises the misaligned trap on its own.
              instr_q <= NOP_INSN;
              fault_q <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end

        BUS: begin
          if (bus.if_kill_i) begin
            if (bus_resp) begin
              cyc_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= KILLED;
            end
          end else if (bus.wb_err_i || (!bus.wb_ack_i && timeout_hit)) begin
            cyc_q   <= 1'b0;
            instr_q <= NOP_INSN;
            fault_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (bus.wb_ack_i) begin
            cyc_q   <= 1'b0;
            instr_q <= bus.wb_dat_i;
            fault_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        KILLED: begin
          if (bus_resp || timeout_hit) begin
            cyc_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        default: begin
          cyc_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_instruction_o       = instr_q;
  assign bus.if_inst_access_fault_o = fault_q;
  assign bus.if_ready_o             = ready;
  assign bus.if_stall_o             = bus.if_req_i & ~ready;

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_sel_o = 4'hF;
  assign bus.wb_we_o  = 1'b0;

endmodule

// File: tb/tb_morty_ifetch_port.sv
// Directed bench for morty_ifetch_port: cycle-by-cycle stimulus with
// hand-computed expectations. Inputs change 1 time unit after the rising
// edge; outputs are checked 1 unit later, well away from the next edge.
module tb_morty_ifetch_port;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  morty_ifetch_port_if bus ();

  morty_ifetch_port #(.TIMEOUT(8'd4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after new inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i  = 1'b0;
    bus.if_kill_i = 1'b0;
    bus.wb_ack_i  = 1'b0;
    bus.wb_err_i  = 1'b0;
    bus.wb_dat_i  = 32'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.if_pc_i = 32'h0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    settle();

    // ---- reset values
    check("rst_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("rst_stb",   {31'h0, bus.wb_stb_o}, 32'h0);
    check("rst_adr",   bus.wb_adr_o, 32'h0);
    check("rst_instr", bus.if_instruction_o, NOP);
    check("rst_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);
    check("rst_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("rst_stall", {31'h0, bus.if_stall_o}, 32'h0);
    check("sel",       {28'h0, bus.wb_sel_o}, 32'hF);
    check("we",        {31'h0, bus.wb_we_o}, 32'h0);

    // ---- basic fetch: PC 0x100, ack in cycle 2
    step();                                   // cycle 0
    bus.if_pc_i = 32'h100; bus.if_req_i = 1'b1;
    settle();
    check("bf_c0_stall", {31'h0, bus.if_stall_o}, 32'h1);
    check("bf_c0_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    step();                                   // cycle 1
    settle();
    check("bf_c1_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    check("bf_c1_stb",   {31'h0, bus.wb_stb_o}, 32'h1);
    check("bf_c1_adr",   bus.wb_adr_o, 32'h100);
    check("bf_c1_stall", {31'h0, bus.if_stall_o}, 32'h1);
    step();                                   // cycle 2
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h00A0_0093;
    settle();
    check("bf_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    check("bf_c2_stall", {31'h0, bus.if_stall_o}, 32'h1);
    check("bf_c2_ready", {31'h0, bus.if_ready_o}, 32'h0);
    step();                                   // cycle 3
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
    settle();
    check("bf_c3_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("bf_c3_instr", bus.if_instruction_o, 32'h00A0_0093);
    check("bf_c3_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);
    check("bf_c3_stall", {31'h0, bus.if_stall_o}, 32'h0);
    check("bf_c3_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    step();                                   // cycle 4: pulse over, no restart
    bus.if_req_i = 1'b0;
    settle();
    check("bf_c4_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("bf_c4_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("bf_c4_instr", bus.if_instruction_o, 32'h00A0_0093);

    // ---- bus error: err and ack together in cycle 1
    step();                                   // cycle 0
    bus.if_pc_i = 32'h200; bus.if_req_i = 1'b1;
    step();                                   // cycle 1
    bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'h1111_1111;
    settle();
    check("be_c1_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    step();                                   // cycle 2
    idle_inputs();
    settle();
    check("be_c2_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("be_c2_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h1);
    check("be_c2_instr", bus.if_instruction_o, NOP);
    check("be_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);

    // ---- timeout with TIMEOUT=4, silent slave
    step();                                   // cycle 0
    bus.if_pc_i = 32'h300; bus.if_req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      settle();
      check($sformatf("to_c%0d_cyc", c), {31'h0, bus.wb_cyc_o}, 32'h1);
      check($sformatf("to_c%0d_ready", c), {31'h0, bus.if_ready_o}, 32'h0);
    end
    step();                                   // cycle 5
    bus.if_req_i = 1'b0;
    settle();
    check("to_c5_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("to_c5_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("to_c5_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h1);
    check("to_c5_instr", bus.if_instruction_o, NOP);

    // ---- plain zero-wait fetch to load a known instruction
    step();                                   // cycle 0
    bus.if_pc_i = 32'h400; bus.if_req_i = 1'b1;
    step();                                   // cycle 1
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678;
    step();                                   // cycle 2
    idle_inputs();
    settle();
    check("zw_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("zw_instr", bus.if_instruction_o, 32'h1234_5678);
    check("zw_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);

    // ---- kill mid-fetch: kill cycle 1, ack cycle 3
    step();                                   // cycle 0
    bus.if_pc_i = 32'h404; bus.if_req_i = 1'b1;
    step();                                   // cycle 1
    bus.if_kill_i = 1'b1;
    settle();
    check("k_c1_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    step();                                   // cycle 2
    bus.if_kill_i = 1'b0;
    settle();
    check("k_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    check("k_c2_ready", {31'h0, bus.if_ready_o}, 32'h0);
    step();                                   // cycle 3
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
    settle();
    check("k_c3_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    check("k_c3_adr",   bus.wb_adr_o, 32'h404);
    step();                                   // cycle 4: new request
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
    bus.if_pc_i = 32'h408;
    settle();
    check("k_c4_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("k_c4_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("k_c4_instr", bus.if_instruction_o, 32'h1234_5678);
    check("k_c4_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);
    step();                                   // cycle 5: issued
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFE_F00D;
    settle();
    check("k_c5_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    check("k_c5_adr",   bus.wb_adr_o, 32'h408);
    step();                                   // cycle 6
    idle_inputs();
    settle();
    check("k_c6_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("k_c6_instr", bus.if_instruction_o, 32'hCAFE_F00D);

    // ---- kill with ack in the same cycle: immediate close, no response
    step();                                   // cycle 0
    bus.if_pc_i = 32'h600; bus.if_req_i = 1'b1;
    step();                                   // cycle 1
    bus.if_kill_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h5555_5555;
    step();                                   // cycle 2
    idle_inputs();
    settle();
    check("ka_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("ka_c2_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("ka_c2_instr", bus.if_instruction_o, 32'hCAFE_F00D);

    // ---- misaligned PC
    step();                                   // cycle 0
    bus.if_pc_i = 32'h102; bus.if_req_i = 1'b1;
    settle();
    check("ma_c0_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("ma_c0_stall", {31'h0, bus.if_stall_o}, 32'h1);
    step();                                   // cycle 1
    settle();
    check("ma_c1_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("ma_c1_ready", {31'h0, bus.if_ready_o}, 32'h1);
    check("ma_c1_instr", bus.if_instruction_o, NOP);
    check("ma_c1_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);
    check("ma_c1_stall", {31'h0, bus.if_stall_o}, 32'h0);
    bus.if_req_i = 1'b0;
    step();                                   // cycle 2
    settle();
    check("ma_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("ma_c2_ready", {31'h0, bus.if_ready_o}, 32'h0);

    // ---- load a faulting result so reset has something to clear
    step();
    bus.if_pc_i = 32'h700; bus.if_req_i = 1'b1;
    step();
    bus.wb_err_i = 1'b1;
    step();
    idle_inputs();
    settle();
    check("pre_rst_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h1);

    // ---- reset mid-operation: rst in cycle 2 of a pending fetch
    step();                                   // cycle 0
    bus.if_pc_i = 32'h500; bus.if_req_i = 1'b1;
    step();                                   // cycle 1
    settle();
    check("rm_c1_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    step();                                   // cycle 2
    rst = 1'b1; bus.if_req_i = 1'b0;
    settle();
    check("rm_c2_cyc",   {31'h0, bus.wb_cyc_o}, 32'h1);
    step();                                   // cycle 3
    rst = 1'b0;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h7777_7777;
    settle();
    check("rm_c3_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);
    check("rm_c3_stb",   {31'h0, bus.wb_stb_o}, 32'h0);
    check("rm_c3_adr",   bus.wb_adr_o, 32'h0);
    check("rm_c3_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("rm_c3_instr", bus.if_instruction_o, NOP);
    check("rm_c3_fault", {31'h0, bus.if_inst_access_fault_o}, 32'h0);
    step();                                   // cycle 4: stray ack ignored
    idle_inputs();
    settle();
    check("rm_c4_ready", {31'h0, bus.if_ready_o}, 32'h0);
    check("rm_c4_instr", bus.if_instruction_o, NOP);
    check("rm_c4_cyc",   {31'h0, bus.wb_cyc_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/morty_ifetch_port.md
# morty_ifetch_port

Instruction-fetch bus port: the responder side of the IF stage's fetch request. It takes the current PC and a fetch request, runs a Wishbone-classic read on the instruction bus, and returns the instruction word plus an access-fault flag. It stalls the IF stage while the fetch is outstanding. It sits between `morty_if_stage` (PC out, instruction and fault in) and the instruction memory or interconnect.

## Interface
- `TIMEOUT` — default 8'd255 — max cycles a bus cycle may wait for ack/err before it is treated as a fault; legal range 1..255.
- `clk_i` input 1 — clock; all logic is rising-edge.
- `rst_i` input 1 — reset; synchronous and active-high.
- `if_pc_i` input 32 — fetch address from the PC register.
- `if_req_i` input 1 — IF stage requests the instruction at `if_pc_i`.
- `if_kill_i` input 1 — flush; discard any outstanding or pending result.
- `if_instruction_o` output 32 — fetched word, registered, held until the next response.
- `if_inst_access_fault_o` output 1 — registered; 1 = the fetch that produced the current response faulted.
- `if_ready_o` output 1 — response valid, one-cycle pulse.
- `if_stall_o` output 1 — combinational; IF stage must hold the PC.
- `wb_adr_o` output 32 — `{pc[31:2],2'b00}`, registered.
- `wb_cyc_o` output 1, `wb_stb_o` output 1 — registered; always equal to each other.
- `wb_sel_o` output 4 — constant 4'hF.
- `wb_we_o` output 1 — constant 0.
- `wb_dat_i` input 32, `wb_ack_i` input 1, `wb_err_i` input 1 — bus response.

## Operation
- States: IDLE, BUS, KILLED. An internal registered `ready_q` drives the outputs:
  - `if_ready_o = ready_q & ~if_kill_i`
  - `if_stall_o = if_req_i & ~if_ready_o`
- Start condition, in IDLE: `if_req_i & ~if_ready_o & ~if_kill_i`.
  - Aligned PC: `if_pc_i[1:0]==0`. Latch `wb_adr_o`, assert cyc/stb, clear the timeout counter, go to BUS.
  - Misaligned PC: no bus cycle. Next cycle `ready_q=1`, instruction=32'h0000_0013 (NOP), fault=0. The IF stage raises the misaligned trap itself. Stay in IDLE.
- BUS, evaluated each cycle in this priority order:
  - `if_kill_i`, with or without ack/err the same cycle:
    - ack or err present → drop cyc/stb, go to IDLE, no response.
    - otherwise → go to KILLED; cyc/stb stay high.
  - `wb_err_i` (wins over a simultaneous ack) → drop cyc/stb; instruction=NOP, fault=1, `ready_q=1`; go to IDLE.
  - `wb_ack_i` → drop cyc/stb; instruction=`wb_dat_i`, fault=0, `ready_q=1`; go to IDLE.
  - Counter reaches `TIMEOUT-1` with no ack/err → handled the same as err.
  - Otherwise → counter +1.
- KILLED:
  - Hold cyc/stb until ack, err or timeout.
  - Then drop cyc/stb and go to IDLE; no `ready_q`, outputs unchanged.
  - `if_kill_i` here has no further effect.
- `ready_q` is high for exactly one cycle after it is set.
- In the `ready_q` cycle no new fetch starts, even with `if_req_i` high, because the PC is still stale. The new PC is sampled the following cycle.
- Timeout counter: 8 bits, cleared on entry to BUS, counts in BUS and KILLED, saturates and never wraps.
- Reset, mid-operation included:
  - State → IDLE; cyc/stb/adr drop to 0 at the next edge.
  - Any pending response is lost; no `if_ready_o`.

## Timing
- Reset values:
  - state IDLE; `wb_cyc_o`/`wb_stb_o` 0; `wb_adr_o` 0.
  - `if_instruction_o` 32'h0000_0013; `if_inst_access_fault_o` 0; `ready_q` 0; counter 0.
  - Combinational outputs: `if_ready_o` 0; `if_stall_o` = `if_req_i`.
- Request at cycle 0 (IDLE) → cyc/stb high from cycle 1.
- Ack at cycle k (k≥1) → cyc/stb low from k+1; `if_ready_o` and data valid in cycle k+1.
- Minimum fetch period: 3 cycles, with a zero-wait-state slave acking in cycle 1.
- Misaligned PC: `if_ready_o` in cycle 1; no bus activity.
- Timeout: no ack/err in cycles 1..TIMEOUT → fault response in cycle TIMEOUT+1.
- Wishbone: adr is stable while cyc is high; no back-to-back cycles (cyc is low for at least 1 cycle between fetches).

## Test plan
- **Basic fetch.** PC=0x100, req held, slave acks in cycle 2 with 0x00A00093.
  - Required: cyc in cycles 1–2, adr=0x100.
  - Required: cycle 3 ready=1, instruction=0x00A00093, fault=0.
  - Required: stall=1 in cycles 0–2 and 0 in cycle 3.
- **Bus error.** err and ack together in cycle 1.
  - Required: cycle 2 ready=1, fault=1, instruction=0x00000013.
- **Timeout.** TIMEOUT=4, slave silent.
  - Required: cyc high cycles 1–4, low from cycle 5.
  - Required: cycle 5 ready=1, fault=1.
- **Kill mid-fetch.** kill in cycle 1, ack in cycle 3 with 0xDEADBEEF.
  - Required: cyc held through cycle 3.
  - Required: no ready; instruction keeps its previous value.
  - Required: a new request in cycle 4 is issued in cycle 5.
- **Misaligned PC.** PC=0x102.
  - Required: cyc never asserted.
  - Required: cycle 1 ready=1, instruction=0x00000013, fault=0.
- **Reset mid-operation.** `rst_i` in cycle 2 of a pending fetch.
  - Required: cyc=0 from cycle 3.
  - Required: no ready; outputs back at reset values.
